// File: rtl/video_timing_gen.sv
// Raster timing generator: registered blank/hsync/vsync, raster position,
// and line/frame markers, advancing one pixel per ce on the pixel clock.
module video_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    output logic        blank,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 13-bit bounds so a 4096 total cannot alias to zero
    localparam logic [12:0] H_ACT_B = 13'(H_ACTIVE);
    localparam logic [12:0] H_SS_B  = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SE_B  = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_B = 13'(V_ACTIVE);
    localparam logic [12:0] V_SS_B  = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SE_B  = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);

    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] vcnt_q, vcnt_d;
    logic        blank_q, blank_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    logic [12:0] h_ext;
    logic [12:0] v_ext;
    logic        in_hsync;
    logic        in_vsync;

    assign h_ext    = {1'b0, hcnt_q};
    assign v_ext    = {1'b0, vcnt_q};
    assign in_hsync = (h_ext >= H_SS_B) && (h_ext < H_SE_B);
    assign in_vsync = (v_ext >= V_SS_B) && (v_ext < V_SE_B);

    always_comb begin
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        blank_d       = blank_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        xpos_d        = xpos_q;
        ypos_d        = ypos_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        if (reset) begin
            hcnt_d        = 12'd0;
            vcnt_d        = 12'd0;
            blank_d       = 1'b1;
            hsync_d       = !HSYNC_POL;
            vsync_d       = !VSYNC_POL;
            xpos_d        = 12'd0;
            ypos_d        = 12'd0;
            line_start_d  = 1'b0;
            frame_start_d = 1'b0;
        end else if (ce) begin
            blank_d       = (h_ext >= H_ACT_B) || (v_ext >= V_ACT_B);
            hsync_d       = in_hsync ? HSYNC_POL : !HSYNC_POL;
            vsync_d       = in_vsync ? VSYNC_POL : !VSYNC_POL;
            xpos_d        = hcnt_q;
            ypos_d        = vcnt_q;
            line_start_d  = (hcnt_q == 12'd0);
            frame_start_d = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
            if (hcnt_q == H_LAST) begin
                hcnt_d = 12'd0;
                vcnt_d = (vcnt_q == V_LAST) ? 12'd0 : vcnt_q + 12'd1;
            end else begin
                hcnt_d = hcnt_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        hcnt_q        <= hcnt_d;
        vcnt_q        <= vcnt_d;
        blank_q       <= blank_d;
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        xpos_q        <= xpos_d;
        ypos_q        <= ypos_d;
        line_start_q  <= line_start_d;
        frame_start_q <= frame_start_d;
    end

    assign blank       = blank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: drivers push expected outputs, monitors pop and compare.
// Default VGA instance covers line timing; a tiny instance covers frame wrap.
module tb_video_timing_gen;

    typedef struct {
        bit          rst;
        bit          adv;
        logic        blank;
        logic        hs;
        logic        vs;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d, ce_d, rst_s, ce_s;
    logic        blank_d, hs_d, vs_d, ls_d, fs_d;
    logic        blank_s, hs_s, vs_s, ls_s, fs_s;
    logic [11:0] x_d, y_d, x_s, y_s;

    int checks = 0;
    int errors = 0;
    int fs_period = 48;

    exp_t q_d[$];
    exp_t q_s[$];

    video_timing_gen u_def (
        .clk(clk), .reset(rst_d), .ce(ce_d),
        .blank(blank_d), .hsync(hs_d), .vsync(vs_d),
        .xpos(x_d), .ypos(y_d),
        .line_start(ls_d), .frame_start(fs_d)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) u_sm (
        .clk(clk), .reset(rst_s), .ce(ce_s),
        .blank(blank_s), .hsync(hs_s), .vsync(vs_s),
        .xpos(x_s), .ypos(y_s),
        .line_start(ls_s), .frame_start(fs_s)
    );

    function automatic exp_t decode(int h, int v, int ha, int hf, int hw,
                                    int va, int vf, int vw, bit hp, bit vp);
        exp_t e;
        e.rst   = 1'b0;
        e.adv   = 1'b1;
        e.blank = (h >= ha) || (v >= va);
        e.hs    = (h >= ha + hf && h < ha + hf + hw) ? hp : !hp;
        e.vs    = (v >= va + vf && v < va + vf + vw) ? vp : !vp;
        e.x     = 12'(h);
        e.y     = 12'(v);
        e.ls    = (h == 0);
        e.fs    = (h == 0) && (v == 0);
        return e;
    endfunction

    function automatic exp_t rst_val(bit hp, bit vp);
        exp_t e;
        e.rst   = 1'b1;
        e.adv   = 1'b0;
        e.blank = 1'b1;
        e.hs    = !hp;
        e.vs    = !vp;
        e.x     = 12'd0;
        e.y     = 12'd0;
        e.ls    = 1'b0;
        e.fs    = 1'b0;
        return e;
    endfunction

    // default-instance model state
    int   hd = 0, vd = 0;
    exp_t ed;

    task automatic step_d(input bit r, input bit c);
        @(negedge clk);
        rst_d = r;
        ce_d  = c;
        if (r) begin
            ed = rst_val(1'b0, 1'b0);
            hd = 0;
            vd = 0;
        end else if (c) begin
            ed = decode(hd, vd, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0);
            hd++;
            if (hd == 800) begin
                hd = 0;
                vd++;
                if (vd == 525) vd = 0;
            end
        end else begin
            ed.adv = 1'b0;
            ed.rst = 1'b0;
        end
        q_d.push_back(ed);
    endtask

    int   hs_m = 0, vs_m = 0;
    exp_t es;

    task automatic step_s(input bit r, input bit c);
        @(negedge clk);
        rst_s = r;
        ce_s  = c;
        if (r) begin
            es = rst_val(1'b1, 1'b1);
            hs_m = 0;
            vs_m = 0;
        end else if (c) begin
            es = decode(hs_m, vs_m, 4, 1, 2, 3, 1, 1, 1'b1, 1'b1);
            hs_m++;
            if (hs_m == 8) begin
                hs_m = 0;
                vs_m++;
                if (vs_m == 6) vs_m = 0;
            end
        end else begin
            es.adv = 1'b0;
            es.rst = 1'b0;
        end
        q_s.push_back(es);
    endtask

    task automatic drive_def();
        repeat (2) step_d(1'b1, 1'b0);
        // run to (300,2), then reset mid-line with ce held high
        repeat (2 * 800 + 301) step_d(1'b0, 1'b1);
        repeat (2) step_d(1'b1, 1'b1);
        repeat (1700) step_d(1'b0, 1'b1);
        step_d(1'b1, 1'b0);
        for (int i = 0; i < 3400; i++) step_d(1'b0, (i % 2) == 0);
    endtask

    task automatic drive_sm();
        fs_period = 48;
        repeat (2) step_s(1'b1, 1'b0);
        repeat (48 * 3 + 1) step_s(1'b0, 1'b1);
        // mid-frame reset
        repeat (20) step_s(1'b0, 1'b1);
        step_s(1'b1, 1'b1);
        repeat (100) step_s(1'b0, 1'b1);
        step_s(1'b1, 1'b0);
        fs_period = 96;
        for (int i = 0; i < 48 * 2 * 3 + 2; i++) step_s(1'b0, (i % 2) == 0);
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic b,
                       input logic h, input logic v, input logic [11:0] x,
                       input logic [11:0] y, input logic l, input logic f);
        checks++;
        if (b !== e.blank || h !== e.hs || v !== e.vs || x !== e.x ||
            y !== e.y || l !== e.ls || f !== e.fs) begin
            errors++;
            $display("FAIL %s got b%b h%b v%b x%0d y%0d ls%b fs%b want b%b h%b v%b x%0d y%0d ls%b fs%b",
                     nm, b, h, v, x, y, l, f,
                     e.blank, e.hs, e.vs, e.x, e.y, e.ls, e.fs);
        end
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    // default-instance monitor with line statistics
    initial begin
        exp_t e;
        int   gap = 0, bl_lo = 0, hs_lo = 0;
        bit   have_line = 1'b0, prev_hs = 1'b1, prev_rst = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (q_d.size() > 0) begin
                e = q_d.pop_front();
                cmp("def_out", e, blank_d, hs_d, vs_d, x_d, y_d, ls_d, fs_d);
                if (e.rst) begin
                    have_line = 1'b0;
                    prev_hs   = 1'b1;
                end else if (e.adv) begin
                    if (prev_rst) begin
                        chk("def_first_fs", int'(fs_d), 1);
                        chk("def_first_blank", int'(blank_d), 0);
                    end
                    if (ls_d === 1'b1) begin
                        if (have_line) begin
                            chk("def_line_period", gap, 800);
                            chk("def_blank_low", bl_lo, 640);
                            chk("def_hsync_low", hs_lo, 96);
                        end
                        have_line = 1'b1;
                        gap   = 0;
                        bl_lo = 0;
                        hs_lo = 0;
                    end
                    if (prev_hs && hs_d === 1'b0)
                        chk("def_hsync_start", int'(x_d), 656);
                    gap++;
                    if (blank_d === 1'b0) bl_lo++;
                    if (hs_d === 1'b0) hs_lo++;
                    prev_hs = hs_d;
                end
                if (e.adv || e.rst) prev_rst = e.rst;
            end
        end
    end

    // small-instance monitor with frame period tracking
    initial begin
        exp_t e;
        int   fclk = 0;
        bit   have_fs = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                cmp("sm_out", e, blank_s, hs_s, vs_s, x_s, y_s, ls_s, fs_s);
                fclk++;
                if (e.rst) begin
                    have_fs = 1'b0;
                end else if (e.adv && fs_s === 1'b1) begin
                    if (have_fs) chk("sm_frame_period", fclk, fs_period);
                    have_fs = 1'b1;
                    fclk = 0;
                end
            end
        end
    end

    initial begin
        rst_d = 1'b1;
        ce_d  = 1'b0;
        rst_s = 1'b1;
        ce_s  = 1'b0;
        fork
            drive_def();
            drive_sm();
        join
        repeat (3) @(posedge clk);
        #2;
        chk("queues_drained", q_d.size() + q_s.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parameterised raster timing generator for the HDMI video path. Produces the registered `blank`, `hsync` and `vsync` sync interface, plus raster position and frame/line markers. These feed the pattern/pixel sources and the TMDS encoders on the pixel clock. Defaults give 640x480@60 VGA timing (800x525 total).

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: hsync width (pixels)
- `H_BP`, 48: horizontal back porch (pixels)
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync width (lines)
- `V_BP`, 33: vertical back porch (lines)
- `HSYNC_POL`, 0: asserted level of `hsync` (0 = active low)
- `VSYNC_POL`, 0: asserted level of `vsync` (0 = active low)

Ports:
- `clk`  in  1  pixel clock
- `reset`  in  1  synchronous, active-high reset
- `ce`  in  1  pixel enable; counters and outputs advance only when high
- `blank`  out  1  high outside the active region
- `hsync`  out  1  horizontal sync, polarity per `HSYNC_POL`
- `vsync`  out  1  vertical sync, polarity per `VSYNC_POL`
- `xpos`  out  12  horizontal count of the presented pixel (0..H_TOTAL-1)
- `ypos`  out  12  vertical count of the presented pixel (0..V_TOTAL-1)
- `line_start`  out  1  one-`ce` pulse when `xpos`==0
- `frame_start`  out  1  one-`ce` pulse when `xpos`==0 and `ypos`==0

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be ≤ 4096; no runtime check is made.
- Internal counters `hcnt` and `vcnt` give the position of the next pixel to present.
- On each `clk` edge with `ce`=1 and `reset`=0:
  - All outputs are loaded from (`hcnt`,`vcnt`).
  - `hcnt` increments. When `hcnt`==H_TOTAL-1 it wraps to 0, and `vcnt` increments. When `vcnt`==V_TOTAL-1 it wraps to 0.
- Output decode for the presented position (h,v):
  - `blank` = (h ≥ H_ACTIVE) or (v ≥ V_ACTIVE).
  - hsync asserted when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, for every pixel of those lines. vsync edges therefore align with h=0.
  - `xpos`=h, `ypos`=v.
  - `line_start` = (h==0).
  - `frame_start` = (h==0 and v==0).
- `ce`=0: counters and all outputs hold their values, including `line_start` and `frame_start`. Consumers qualify markers with `ce`.
- Reset (any cycle, including mid-line or mid-frame):
  - Counters go to (0,0).
  - `blank`=1, `hsync`=!HSYNC_POL, `vsync`=!VSYNC_POL, `xpos`=0, `ypos`=0, `line_start`=0, `frame_start`=0.
  - Reset has priority over `ce`.
- Only wrap-around at H_TOTAL-1 and V_TOTAL-1 is defined; counters never reach H_TOTAL or V_TOTAL.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency: the first `ce` edge after reset deasserts presents (0,0): `blank`=0, `line_start`=1, `frame_start`=1.
- Each `ce` edge advances exactly one pixel. A frame lasts H_TOTAL*V_TOTAL `ce` edges (420000 at defaults).
- `hsync` asserts on the edge presenting h=H_ACTIVE+H_FP (656). It deasserts on the edge presenting h=H_ACTIVE+H_FP+H_SYNC (752).
- `vsync` asserts on the edge presenting (0, V_ACTIVE+V_FP) = (0,490). It deasserts on the edge presenting (0,492).
- `blank` rises on the edge presenting h=640 of an active line. It falls on the edge presenting h=0 of lines 0..479.

## Test plan
- Reset then `ce`=1 constant, default parameters:
  - First edge gives `xpos`=0, `ypos`=0, `blank`=0, `line_start`=1, `frame_start`=1.
  - `frame_start` then recurs every 420000 cycles exactly.
- Line check at defaults:
  - Per line, `blank` is low for 640 cycles and high for 160.
  - `hsync` is low for exactly 96 cycles, starting at `xpos`=656.
  - `line_start` occurs every 800 cycles.
- Frame check at defaults:
  - `vsync` is low for exactly 2×800 cycles, starting at (`xpos`=0, `ypos`=490).
  - `blank` stays high for all of lines 480..524.
  - `ypos` wraps 524→0.
- Reset mid-frame at (`xpos`=300, `ypos`=200):
  - Next edge shows reset values (`blank`=1, syncs deasserted).
  - First edge after release presents (0,0) with `frame_start`=1.
- `ce` toggling 1/0 every cycle:
  - Outputs hold on `ce`=0 cycles.
  - Sequence of presented positions is identical to the `ce`=1 run; the frame spans 840000 clocks.
- Small positive-polarity config (H 4/1/2/1, V 3/1/1/1, HSYNC_POL=VSYNC_POL=1):
  - `hsync`=1 at `xpos` 5..6.
  - `vsync`=1 for all of `ypos`=4.
  - Wrap at `xpos`=7 and `ypos`=5.
